// File: rtl/data_req_ctrl_pkg.sv
// Shared encodings and transaction records for the data-side request controller.
package data_req_ctrl_pkg;

  // Bus access size encodings
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Request sequencer states
  localparam logic [0:0] ST_IDLE      = 1'b0;
  localparam logic [0:0] ST_WAIT_ADDR = 1'b1;

  // Default limit on outstanding plus buffered transactions
  localparam int MAX_OUT_DEF = 2;

  // Request held toward the bus
  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Response handed to MEM
  typedef struct packed {
    logic        wr;
    logic [31:0] rdata;
  } mem_resp_t;

  // Store acks carry no data, so their rdata is forced to zero
  function automatic mem_resp_t mk_resp(input logic wr, input logic [31:0] rdata);
    mem_resp_t r;
    r.wr    = wr;
    r.rdata = wr ? 32'd0 : rdata;
    return r;
  endfunction

endpackage

// File: rtl/data_req_ctrl_resp_fifo.sv
// Response buffer: in-order FIFO of {wr, rdata}, synchronous clear, no bypass.
module resp_fifo
  import data_req_ctrl_pkg::*;
#(
  parameter int DEPTH = MAX_OUT_DEF,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  mem_resp_t        push_data,
  input  logic             pop,
  output logic             valid,
  output mem_resp_t        head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  mem_resp_t        mem_q [DEPTH];
  mem_resp_t        mem_d [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  assign valid = (cnt_q != '0);
  assign head  = mem_q[rd_q];
  assign count = cnt_q;
  assign do_pop = pop && valid;

  // Next pointers, count and storage; clear wins over push/pop
  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_data;
        wr_d        = ptr_inc(wr_q);
      end
      if (do_pop) rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(do_pop);
    end
  end

  // Pointer/count state
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, no reset needed: nothing is read before it is written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !clr && !do_pop && cnt_q == CNT_FULL));

endmodule

// File: rtl/data_req_ctrl.sv
// Data-side SRAM-like bus sequencer: holds EX requests until addr_ok, tracks
// outstanding transactions, buffers responses for MEM and drops responses of
// transactions killed by a WB flush.
module data_req_ctrl
  import data_req_ctrl_pkg::*;
#(
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int CNT_W   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_req_valid,
  input  logic        ex_wr,
  input  logic [1:0]  ex_size,
  input  logic [3:0]  ex_wstrb,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic        ex_req_ready,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        ms_resp_valid,
  output logic        ms_resp_wr,
  output logic [31:0] ms_resp_rdata,
  input  logic        ms_resp_ready,
  output logic        busy
);

  localparam logic [CNT_W:0] MAX_TOT = (CNT_W + 1)'(MAX_OUT);

  logic [0:0]         state_q, state_d;
  mem_req_t           hold_q, hold_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   disc_q, disc_d;
  logic [MAX_OUT-1:0] tags_q, tags_d;   // wr bit of each outstanding txn, oldest at [0]
  logic [CNT_W-1:0]   ins_idx;

  logic             in_wait, acc_addr, take, drop, push;
  logic [CNT_W:0]   total;
  logic [CNT_W-1:0] buf_cnt;
  logic             fifo_valid;
  mem_resp_t        fifo_head, push_data;

  assign in_wait  = (state_q == ST_WAIT_ADDR);
  assign acc_addr = in_wait && data_sram_addr_ok;
  assign total    = {1'b0, out_q} + {1'b0, buf_cnt};

  // Capacity counts outstanding and buffered entries so the FIFO can never overflow
  assign ex_req_ready = !reset && !in_wait && !flush && (total < MAX_TOT);
  assign take         = ex_req_valid && ex_req_ready;

  // Responses owed to flushed transactions are swallowed; so is one landing in the flush cycle
  assign drop      = data_sram_data_ok && (disc_q != '0);
  assign push      = data_sram_data_ok && !drop && !flush;
  assign push_data = mk_resp(tags_q[0], data_sram_rdata);

  assign data_sram_req   = in_wait;
  assign data_sram_wr    = hold_q.wr;
  assign data_sram_size  = hold_q.size;
  assign data_sram_wstrb = hold_q.wstrb;
  assign data_sram_addr  = hold_q.addr;
  assign data_sram_wdata = hold_q.wdata;

  assign ms_resp_valid = fifo_valid;
  assign ms_resp_wr    = fifo_head.wr;
  assign ms_resp_rdata = fifo_head.rdata;

  assign busy = in_wait || (out_q != '0) || (buf_cnt != '0);

  // FSM, hold register, outstanding/discard counters and wr-tag queue
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    tags_d  = tags_q;
    ins_idx = '0;
    if (take) begin
      state_d = ST_WAIT_ADDR;
      hold_d  = '{wr: ex_wr, size: ex_size, wstrb: ex_wstrb, addr: ex_addr, wdata: ex_wdata};
    end else if (acc_addr) begin
      state_d = ST_IDLE;
    end

    out_d = out_q + CNT_W'(acc_addr) - CNT_W'(data_sram_data_ok);

    // A flush re-derives the kill count from everything still owed a response,
    // including a request still waiting for addr_ok
    if (flush) disc_d = out_d + CNT_W'(state_d == ST_WAIT_ADDR);
    else       disc_d = disc_q - CNT_W'(drop);

    if (data_sram_data_ok) tags_d = tags_q >> 1;
    ins_idx = out_q - CNT_W'(data_sram_data_ok);
    for (int i = 0; i < MAX_OUT; i++) begin
      if (acc_addr && (ins_idx == CNT_W'(i))) tags_d[i] = hold_q.wr;
    end
  end

  // Control and hold-register state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      hold_q  <= '{wr: 1'b0, size: SZ_B, wstrb: 4'd0, addr: 32'd0, wdata: 32'd0};
      out_q   <= '0;
      disc_q  <= '0;
      tags_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      tags_q  <= tags_d;
    end
  end

  resp_fifo #(
    .DEPTH (MAX_OUT),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (ms_resp_ready),
    .valid     (fifo_valid),
    .head      (fifo_head),
    .count     (buf_cnt)
  );

  a_dok_legal: assert property (@(posedge clk) disable iff (reset)
    data_sram_data_ok |-> (out_q != '0));
  a_out_nowrap: assert property (@(posedge clk) disable iff (reset)
    !(acc_addr && !data_sram_data_ok && out_q == CNT_W'(MAX_OUT)));

endmodule

// File: tb/tb_data_req_ctrl.sv
// Bench for data_req_ctrl: directed vector table, multi-cycle corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_data_req_ctrl;
  import data_req_ctrl_pkg::*;

  // Depth 3 so that two outstanding plus one buffered transaction is reachable
  localparam int MO = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_req_valid, ex_wr;
  logic [1:0]  ex_size;
  logic [3:0]  ex_wstrb;
  logic [31:0] ex_addr, ex_wdata;
  logic        ex_req_ready, flush;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_resp_valid, ms_resp_wr;
  logic [31:0] ms_resp_rdata;
  logic        ms_resp_ready, busy;

  always #5 clk = ~clk;

  data_req_ctrl #(.MAX_OUT(MO), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .ex_req_valid(ex_req_valid), .ex_wr(ex_wr), .ex_size(ex_size), .ex_wstrb(ex_wstrb),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_req_ready(ex_req_ready), .flush(flush),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .ms_resp_valid(ms_resp_valid), .ms_resp_wr(ms_resp_wr), .ms_resp_rdata(ms_resp_rdata),
    .ms_resp_ready(ms_resp_ready), .busy(busy)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic clr_in();
    ex_req_valid = 0; ex_wr = 0; ex_size = SZ_W; ex_wstrb = 4'hF;
    ex_addr = 0; ex_wdata = 0; flush = 0;
    data_sram_addr_ok = 0; data_sram_data_ok = 0; data_sram_rdata = 0;
    ms_resp_ready = 0;
  endtask

  // New cycle: inputs change away from the active edge
  task automatic nx();
    @(negedge clk);
    clr_in();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        vld;  logic [31:0] addr;
    logic        aok;  logic        dok;  logic [31:0] rdata; logic rrdy;
    logic        e_rdy; logic       e_req; logic [31:0] e_addr;
    logic        e_rv; logic [31:0] e_rdat; logic e_busy;
  } vec_t;

  function automatic vec_t V(input logic vld, input logic [31:0] addr, input logic aok,
                             input logic dok, input logic [31:0] rdata, input logic rrdy,
                             input logic e_rdy, input logic e_req, input logic [31:0] e_addr,
                             input logic e_rv, input logic [31:0] e_rdat, input logic e_busy);
    vec_t v;
    v.vld = vld; v.addr = addr; v.aok = aok; v.dok = dok; v.rdata = rdata; v.rrdy = rrdy;
    v.e_rdy = e_rdy; v.e_req = e_req; v.e_addr = e_addr;
    v.e_rv = e_rv; v.e_rdat = e_rdat; v.e_busy = e_busy;
    return v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic wr; logic [1:0] size; logic [3:0] wstrb; logic [31:0] addr, wdata; bit killed;
  } mtx_t;
  typedef struct { logic wr; logic [31:0] rdata; } mrsp_t;

  mtx_t  m_out[$];
  mrsp_t m_rsp[$];
  mtx_t  m_hold;
  bit    m_held;

  initial begin
    vec_t tv[20];
    mtx_t t;
    bit   exp_rdy;

    tv[0]  = V(0, 32'h0,    0, 0, 32'h0,        0, 1, 0, 32'h0,    0, 32'h0,        0);
    tv[1]  = V(1, 32'h1000, 0, 0, 32'h0,        0, 1, 0, 32'h0,    0, 32'h0,        0);
    tv[2]  = V(0, 32'h0,    1, 0, 32'h0,        0, 0, 1, 32'h1000, 0, 32'h0,        1);
    tv[3]  = V(0, 32'h0,    0, 1, 32'hDEADBEEF, 0, 1, 0, 32'h0,    0, 32'h0,        1);
    tv[4]  = V(0, 32'h0,    0, 0, 32'h0,        1, 1, 0, 32'h0,    1, 32'hDEADBEEF, 1);
    tv[5]  = V(0, 32'h0,    0, 0, 32'h0,        0, 1, 0, 32'h0,    0, 32'h0,        0);
    tv[6]  = V(1, 32'h10,   0, 0, 32'h0,        0, 1, 0, 32'h0,    0, 32'h0,        0);
    tv[7]  = V(0, 32'h0,    1, 0, 32'h0,        0, 0, 1, 32'h10,   0, 32'h0,        1);
    tv[8]  = V(1, 32'h20,   0, 1, 32'h11,       0, 1, 0, 32'h0,    0, 32'h0,        1);
    tv[9]  = V(0, 32'h0,    1, 0, 32'h0,        0, 0, 1, 32'h20,   1, 32'h11,       1);
    tv[10] = V(1, 32'h30,   0, 1, 32'h22,       0, 1, 0, 32'h0,    1, 32'h11,       1);
    tv[11] = V(0, 32'h0,    1, 0, 32'h0,        0, 0, 1, 32'h30,   1, 32'h11,       1);
    tv[12] = V(1, 32'h40,   0, 1, 32'h33,       0, 0, 0, 32'h0,    1, 32'h11,       1);
    tv[13] = V(1, 32'h40,   0, 0, 32'h0,        0, 0, 0, 32'h0,    1, 32'h11,       1);
    tv[14] = V(1, 32'h40,   0, 0, 32'h0,        1, 0, 0, 32'h0,    1, 32'h11,       1);
    tv[15] = V(1, 32'h40,   0, 0, 32'h0,        1, 1, 0, 32'h0,    1, 32'h22,       1);
    tv[16] = V(0, 32'h0,    1, 0, 32'h0,        1, 0, 1, 32'h40,   1, 32'h33,       1);
    tv[17] = V(0, 32'h0,    0, 1, 32'h44,       0, 1, 0, 32'h0,    0, 32'h0,        1);
    tv[18] = V(0, 32'h0,    0, 0, 32'h0,        1, 1, 0, 32'h0,    1, 32'h44,       1);
    tv[19] = V(0, 32'h0,    0, 0, 32'h0,        0, 1, 0, 32'h0,    0, 32'h0,        0);

    // ---- reset ----
    reset = 1'b1;
    clr_in();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdy",  ex_req_ready, 0);
    chk("rst_req",  data_sram_req, 0);
    chk("rst_rv",   ms_resp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fields", {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata[24:0]}, 0);
    @(negedge clk);
    reset = 1'b0;

    // ---- table ----
    for (int i = 0; i < 20; i++) begin
      nx();
      ex_req_valid = tv[i].vld; ex_addr = tv[i].addr;
      data_sram_addr_ok = tv[i].aok; data_sram_data_ok = tv[i].dok;
      data_sram_rdata = tv[i].rdata; ms_resp_ready = tv[i].rrdy;
      #1;
      chk($sformatf("tv%0d_rdy", i),  ex_req_ready,  tv[i].e_rdy);
      chk($sformatf("tv%0d_req", i),  data_sram_req, tv[i].e_req);
      chk($sformatf("tv%0d_rv", i),   ms_resp_valid, tv[i].e_rv);
      chk($sformatf("tv%0d_busy", i), busy,          tv[i].e_busy);
      if (tv[i].e_req) chk($sformatf("tv%0d_addr", i), data_sram_addr, tv[i].e_addr);
      if (tv[i].e_rv)  chk($sformatf("tv%0d_resp", i), {ms_resp_wr, ms_resp_rdata}, {1'b0, tv[i].e_rdat});
    end

    // ---- store with addr_ok held off 3 cycles ----
    nx();
    ex_req_valid = 1; ex_wr = 1; ex_size = SZ_H; ex_wstrb = 4'h3; ex_addr = 32'h80; ex_wdata = 32'hAABB;
    #1;
    chk("st_rdy", ex_req_ready, 1);
    for (int k = 0; k < 4; k++) begin
      nx();
      data_sram_addr_ok = (k == 3);
      #1;
      chk($sformatf("st_req%0d", k), data_sram_req, 1);
      chk($sformatf("st_ctl%0d", k), {data_sram_wr, data_sram_size, data_sram_wstrb}, {1'b1, SZ_H, 4'h3});
      chk($sformatf("st_dat%0d", k), {data_sram_addr, data_sram_wdata}, {32'h80, 32'hAABB});
    end
    nx();
    data_sram_data_ok = 1; data_sram_rdata = 32'hFFFFFFFF;
    #1;
    chk("st_rv_early", ms_resp_valid, 0);
    nx();
    ms_resp_ready = 1;
    #1;
    chk("st_rv", ms_resp_valid, 1);
    chk("st_ack", {ms_resp_wr, ms_resp_rdata}, {1'b1, 32'h0});
    nx(); #1;
    chk("st_busy_end", busy, 0);

    // ---- flush while request waits for addr_ok ----
    nx(); ex_req_valid = 1; ex_addr = 32'h50; #1;
    chk("fw_acc", ex_req_ready, 1);
    nx(); flush = 1; ex_req_valid = 1; #1;
    chk("fw_req_hold", data_sram_req, 1);
    nx(); data_sram_addr_ok = 1; #1;
    chk("fw_addr", data_sram_addr, 32'h50);
    nx(); data_sram_data_ok = 1; data_sram_rdata = 32'h99; #1;
    chk("fw_rv0", ms_resp_valid, 0);
    nx(); #1;
    chk("fw_rv1", ms_resp_valid, 0);
    chk("fw_busy", busy, 0);
    chk("fw_disc", dut.disc_q, 0);

    // ---- flush with two outstanding and one buffered ----
    nx(); ex_req_valid = 1; ex_addr = 32'h100; #1;
    nx(); data_sram_addr_ok = 1; #1;
    nx(); ex_req_valid = 1; ex_addr = 32'h104; #1;
    nx(); data_sram_addr_ok = 1; #1;
    nx(); data_sram_data_ok = 1; data_sram_rdata = 32'h61; ex_req_valid = 1; ex_addr = 32'h108; #1;
    chk("f3_acc3", ex_req_ready, 1);
    nx(); data_sram_addr_ok = 1; #1;
    chk("f3_buf", {ms_resp_valid, ms_resp_rdata}, {1'b1, 32'h61});
    nx(); flush = 1; #1;
    chk("f3_rdy_flush", ex_req_ready, 0);
    nx(); data_sram_data_ok = 1; data_sram_rdata = 32'h62; #1;
    chk("f3_cleared", ms_resp_valid, 0);
    nx(); data_sram_data_ok = 1; data_sram_rdata = 32'h63; #1;
    chk("f3_drop1", ms_resp_valid, 0);
    nx(); ex_req_valid = 1; ex_addr = 32'h2000; #1;
    chk("f3_drop2", ms_resp_valid, 0);
    chk("f3_idle", {busy, dut.disc_q}, 0);
    nx(); data_sram_addr_ok = 1; #1;
    chk("f3_new_addr", {data_sram_req, data_sram_addr}, {1'b1, 32'h2000});
    nx(); data_sram_data_ok = 1; data_sram_rdata = 32'h55; #1;
    nx(); ms_resp_ready = 1; #1;
    chk("f3_new_resp", {ms_resp_valid, ms_resp_wr, ms_resp_rdata}, {1'b1, 1'b0, 32'h55});
    nx(); #1;
    chk("f3_end_busy", busy, 0);

    // ---- flush coincident with data_ok; EX request in flush cycle ignored ----
    nx(); ex_req_valid = 1; ex_addr = 32'h200; #1;
    nx(); data_sram_addr_ok = 1; #1;
    nx(); data_sram_data_ok = 1; data_sram_rdata = 32'h77; flush = 1; ex_req_valid = 1; ex_addr = 32'h300; #1;
    chk("fd_rdy", ex_req_ready, 0);
    nx(); #1;
    chk("fd_rv", ms_resp_valid, 0);
    chk("fd_req", data_sram_req, 0);
    chk("fd_cnt", {busy, dut.disc_q, dut.out_q}, 0);

    // ---- randomized traffic against the model ----
    m_out.delete(); m_rsp.delete(); m_held = 0;
    for (int c = 0; c < 3000; c++) begin
      nx();
      ex_req_valid = $urandom_range(0, 1);
      ex_wr    = $urandom_range(0, 1);
      ex_size  = 2'($urandom_range(0, 2));
      ex_wstrb = 4'($urandom);
      ex_addr  = $urandom;
      ex_wdata = $urandom;
      data_sram_addr_ok = m_held ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
      data_sram_data_ok = (m_out.size() > 0) && ($urandom_range(0, 2) == 0);
      data_sram_rdata   = $urandom;
      ms_resp_ready     = $urandom_range(0, 1);
      flush             = ($urandom_range(0, 24) == 0);
      #1;
      exp_rdy = !m_held && !flush && ((m_out.size() + m_rsp.size()) < MO);
      chk("r_rdy",  ex_req_ready, exp_rdy);
      chk("r_req",  data_sram_req, m_held);
      chk("r_rv",   ms_resp_valid, m_rsp.size() > 0);
      chk("r_busy", busy, m_held || m_out.size() > 0 || m_rsp.size() > 0);
      if (m_held) begin
        chk("r_ctl", {data_sram_wr, data_sram_size, data_sram_wstrb}, {m_hold.wr, m_hold.size, m_hold.wstrb});
        chk("r_dat", {data_sram_addr, data_sram_wdata}, {m_hold.addr, m_hold.wdata});
      end
      if (m_rsp.size() > 0) chk("r_resp", {ms_resp_wr, ms_resp_rdata}, {m_rsp[0].wr, m_rsp[0].rdata});

      // advance model through the coming clock edge
      if (m_rsp.size() > 0 && ms_resp_ready) void'(m_rsp.pop_front());
      if (data_sram_data_ok) begin
        t = m_out.pop_front();
        if (!t.killed && !flush) m_rsp.push_back('{t.wr, t.wr ? 32'h0 : data_sram_rdata});
      end
      if (m_held && data_sram_addr_ok) begin
        m_out.push_back(m_hold);
        m_held = 0;
      end else if (!m_held && ex_req_valid && exp_rdy) begin
        m_hold = '{ex_wr, ex_size, ex_wstrb, ex_addr, ex_wdata, 1'b0};
        m_held = 1;
      end
      if (flush) begin
        m_rsp.delete();
        foreach (m_out[i]) m_out[i].killed = 1;
        m_hold.killed = 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
